// File: rtl/mem_write_checker.sv
// Self-check monitor for the data-memory write port: arms on a begin-symbol write to the test
// port, then scores each later test-port write against a run-time loaded expected table.
module mem_write_checker #(
  parameter int unsigned ADDR_W              = 30,
  parameter int unsigned DATA_W              = 32,
  parameter int unsigned DEPTH               = 64,
  localparam int unsigned IDX_W              = $clog2(DEPTH),
  parameter logic [ADDR_W-1:0] TEST_PORT     = 'h40,
  parameter logic [DATA_W-1:0] BEGIN_SYM     = 'h932,
  parameter int unsigned DUR_W               = 16,
  parameter logic [DUR_W-1:0] TIMEOUT        = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  input  logic              ld_we,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [IDX_W:0]    num_chk,
  output logic [7:0]        error_num,
  output logic [DUR_W-1:0]  duration,
  output logic              finish,
  output logic              timeout,
  output logic              busy,
  output logic              err_valid,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data
);

  localparam logic [IDX_W:0]   DepthW      = (IDX_W + 1)'(DEPTH);
  localparam logic [DUR_W-1:0] TimeoutLast = TIMEOUT - 1'b1;

  typedef enum logic [1:0] {StIdle, StCheck, StReport, StTimeout} state_e;

  state_e              state_q, state_d;
  logic [7:0]          err_num_q, err_num_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [IDX_W:0]      idx_q, idx_d;
  logic [IDX_W:0]      cnt_q, cnt_d;
  logic                wen_q;
  logic                err_valid_q, err_valid_d;
  logic [IDX_W-1:0]    fidx_q, fidx_d;
  logic [DATA_W-1:0]   fdata_q, fdata_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   exp_word;
  logic                hit;
  logic                done;
  logic                to_hit;
  logic [IDX_W:0]      num_clamped;

  // A write held across stall cycles only counts on its rising edge.
  assign hit         = wen & ~wen_q & (addr == TEST_PORT);
  assign exp_word    = mem_q[idx_q[IDX_W-1:0]];
  assign done        = (idx_q == cnt_q);
  assign to_hit      = (TIMEOUT != '0) && (dur_q == TimeoutLast);
  assign num_clamped = (num_chk > DepthW) ? DepthW : num_chk;

  // Expected table has no reset so it survives a re-arm.
  always_ff @(posedge clk) begin
    if (ld_we && (state_q == StIdle)) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      err_num_q   <= 8'd255;
      dur_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      wen_q       <= 1'b0;
      err_valid_q <= 1'b0;
      fidx_q      <= '0;
      fdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      err_num_q   <= err_num_d;
      dur_q       <= dur_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen;
      err_valid_q <= err_valid_d;
      fidx_q      <= fidx_d;
      fdata_q     <= fdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    err_num_d   = err_num_q;
    dur_d       = dur_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_valid_d = err_valid_q;
    fidx_d      = fidx_q;
    fdata_d     = fdata_q;
    unique case (state_q)
      StIdle: begin
        if (hit && (data == BEGIN_SYM)) begin
          state_d     = StCheck;
          err_num_d   = 8'd0;
          dur_d       = '0;
          idx_d       = '0;
          err_valid_d = 1'b0;
          cnt_d       = num_clamped;
        end
      end
      StCheck: begin
        dur_d = (dur_q == '1) ? dur_q : dur_q + 1'b1;
        // Completion takes priority over timeout in the same cycle.
        if (done) begin
          state_d = StReport;
        end else begin
          if (to_hit) begin
            state_d = StTimeout;
          end
          if (hit) begin
            idx_d = idx_q + 1'b1;
            if (data != exp_word) begin
              err_num_d = (err_num_q == 8'hFF) ? err_num_q : err_num_q + 8'd1;
              if (!err_valid_q) begin
                err_valid_d = 1'b1;
                fidx_d      = idx_q[IDX_W-1:0];
                fdata_d     = data;
              end
            end
          end
        end
      end
      StReport, StTimeout: begin
      end
      default: state_d = StIdle;
    endcase
  end

  assign error_num      = err_num_q;
  assign duration       = dur_q;
  assign finish         = (state_q == StReport) || (state_q == StTimeout);
  assign timeout        = (state_q == StTimeout);
  assign busy           = (state_q == StCheck);
  assign err_valid      = err_valid_q;
  assign first_err_idx  = fidx_q;
  assign first_err_data = fdata_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed/randomized bench for mem_write_checker with a queue-based scoring model.
module tb_mem_write_checker;

  localparam int DEPTH = 64;
  localparam logic [29:0] TP    = 30'h40;
  localparam logic [31:0] BEGIN = 32'h0000_0932;

  logic        clk = 1'b0;
  logic        rst, rst_to;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen, ld_we;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic [6:0]  num_chk;

  logic [7:0]  error_num, error_num_to;
  logic [15:0] duration, duration_to;
  logic        finish, finish_to, timeout, timeout_to, busy, busy_to;
  logic        err_valid, err_valid_to;
  logic [5:0]  first_err_idx, first_err_idx_to;
  logic [31:0] first_err_data, first_err_data_to;

  always #5 clk = ~clk;

  mem_write_checker dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .num_chk(num_chk),
    .error_num(error_num), .duration(duration), .finish(finish), .timeout(timeout),
    .busy(busy), .err_valid(err_valid), .first_err_idx(first_err_idx),
    .first_err_data(first_err_data)
  );

  mem_write_checker #(.TIMEOUT(16'd100)) dut_to (
    .clk(clk), .rst(rst_to), .addr(addr), .data(data), .wen(wen),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .num_chk(num_chk),
    .error_num(error_num_to), .duration(duration_to), .finish(finish_to),
    .timeout(timeout_to), .busy(busy_to), .err_valid(err_valid_to),
    .first_err_idx(first_err_idx_to), .first_err_data(first_err_data_to)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int arm_cyc, fin_cyc, fin_to_cyc, cnt;
  bit fin_seen, fin_to_seen;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wr_q [$];
  logic [31:0] fib [33];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (finish && !fin_seen) begin fin_seen = 1; fin_cyc = cyc; end
    if (finish_to && !fin_to_seen) begin fin_to_seen = 1; fin_to_cyc = cyc; end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    fin_seen = 0;
    fin_to_seen = 0;
  endtask

  task automatic load(input int i, input logic [31:0] v);
    ld_addr = 6'(i); ld_data = v; ld_we = 1'b1;
    tick();
    ld_we = 1'b0;
    ref_mem[i] = v;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input int hold, input int gap);
    addr = a; data = d; wen = 1'b1;
    repeat (hold) tick();
    wen = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic arm(input int n);
    num_chk = 7'(n);
    arm_cyc = cyc + 1;
    wr(TP, BEGIN, 1, 1);
    wr_q.delete();
    cnt = (n > DEPTH) ? DEPTH : n;
  endtask

  task automatic send(input logic [31:0] d, input int hold);
    wr(TP, d, hold, $urandom_range(1, 3));
    wr_q.push_back(d);
  endtask

  // Score the run from the list of writes sent after arming.
  task automatic verify(input string tag);
    int k, e, fi, n;
    logic [31:0] fd;
    bit v;
    k = 0; e = 0; fi = 0; fd = '0; v = 0;
    while (!fin_seen && k < 500) begin tick(); k++; end
    check({tag, "/finish"}, 32'(fin_seen), 32'd1);
    n = (wr_q.size() < cnt) ? wr_q.size() : cnt;
    for (int i = 0; i < n; i++) begin
      if (wr_q[i] !== ref_mem[i]) begin
        if (!v) begin v = 1; fi = i; fd = wr_q[i]; end
        e++;
      end
    end
    check({tag, "/error_num"}, 32'(error_num), 32'((e > 255) ? 255 : e));
    check({tag, "/err_valid"}, 32'(err_valid), 32'(v));
    if (v) begin
      check({tag, "/first_idx"}, 32'(first_err_idx), 32'(fi));
      check({tag, "/first_data"}, first_err_data, fd);
    end
    check({tag, "/duration"}, 32'(duration), 32'(fin_cyc - arm_cyc));
    check({tag, "/timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    addr = '0; data = '0; wen = 0; ld_we = 0; ld_addr = '0; ld_data = '0; num_chk = '0;
    rst = 1'b1; rst_to = 1'b1;
    #2;
    rst = 1'b0; rst_to = 1'b0;
    tick();
    check("rst/error_num", 32'(error_num), 32'd255);
    check("rst/duration", 32'(duration), 32'd0);
    check("rst/finish", 32'(finish), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/timeout", 32'(timeout), 32'd0);
    check("rst/err_valid", 32'(err_valid), 32'd0);
    check("rst/first_idx", 32'(first_err_idx), 32'd0);
    check("rst/first_data", first_err_data, 32'd0);
    rst = 1'b1;

    // Fibonacci up/down table.
    fib[0] = 1; fib[1] = 1;
    for (int i = 2; i < 17; i++) fib[i] = fib[i-1] + fib[i-2];
    for (int i = 0; i < 15; i++) fib[17+i] = fib[15-i];
    fib[32] = 32'hD5D;
    for (int i = 0; i < DEPTH; i++) load(i, (i < 33) ? fib[i] : $urandom);

    // Clean pass.
    arm(33);
    check("t1/busy", 32'(busy), 32'd1);
    check("t1/error_num_armed", 32'(error_num), 32'd0);
    for (int i = 0; i < 33; i++) send(ref_mem[i], 1);
    verify("t1");

    // Two corrupt writes.
    do_reset();
    arm(33);
    for (int i = 0; i < 33; i++) send((i == 5) ? 32'd9 : (i == 17) ? 32'd0 : ref_mem[i], 1);
    verify("t2");
    check("t2/err2", 32'(error_num), 32'd2);

    // Stalled writes held three cycles.
    do_reset();
    arm(33);
    for (int i = 0; i < 33; i++) send(ref_mem[i], 3);
    verify("t3");

    // Randomized tables, lengths and corruptions.
    for (int it = 0; it < 3; it++) begin
      int n;
      n = $urandom_range(1, 40);
      do_reset();
      for (int i = 0; i < n; i++) load(i, $urandom);
      arm(n);
      for (int i = 0; i < n; i++)
        send(($urandom_range(0, 3) == 0) ? (ref_mem[i] ^ 32'h10) : ref_mem[i],
             $urandom_range(1, 2));
      verify("rand");
    end

    // Zero-length check and num_chk above DEPTH.
    do_reset();
    arm(0);
    verify("zero");
    check("zero/duration1", 32'(duration), 32'd1);
    do_reset();
    arm(100);
    for (int i = 0; i < DEPTH; i++) send(ref_mem[i], 1);
    verify("clamp");

    // Timeout instance: 3 writes of 10, one corrupt.
    do_reset();
    rst_to = 1'b1;
    arm(10);
    send(ref_mem[0], 1);
    send(ref_mem[1] + 32'd1, 1);
    send(ref_mem[2], 1);
    for (int k = 0; k < 300 && !fin_to_seen; k++) tick();
    check("to/finish", 32'(finish_to), 32'd1);
    check("to/timeout", 32'(timeout_to), 32'd1);
    check("to/duration", 32'(duration_to), 32'd100);
    check("to/cycles", 32'(fin_to_cyc - arm_cyc), 32'd100);
    check("to/error_num", 32'(error_num_to), 32'd1);
    check("to/first_idx", 32'(first_err_idx_to), 32'd1);
    repeat (3) tick();
    check("to/sticky", 32'(timeout_to), 32'd1);
    rst_to = 1'b0;

    // Idle ignores foreign address and non-begin data; loads ignored in CHECK.
    do_reset();
    wr(30'h41, BEGIN, 1, 1);
    wr(TP, 32'h1234, 1, 2);
    check("idle/busy", 32'(busy), 32'd0);
    check("idle/error_num", 32'(error_num), 32'd255);
    arm(4);
    ld_addr = 6'd0; ld_data = ~ref_mem[0]; ld_we = 1'b1;
    tick();
    ld_we = 1'b0;
    for (int i = 0; i < 4; i++) send(ref_mem[i], 1);
    verify("ldchk");

    // Reset mid-check, then re-arm against the retained table.
    do_reset();
    arm(33);
    for (int i = 0; i < 10; i++) send(ref_mem[i] ^ 32'h1, 1);
    rst = 1'b0;
    #2;
    check("mid/error_num", 32'(error_num), 32'd255);
    check("mid/duration", 32'(duration), 32'd0);
    check("mid/busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    fin_seen = 0;
    arm(33);
    for (int i = 0; i < 33; i++) send(ref_mem[i], 1);
    verify("rearm");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
